// File: rtl/out_port_rr_arbiter.sv
// Per-output-port wormhole arbiter: grants one input whose head flit targets this port and holds it until the tail crosses.
// Grant one cycle after request; one idle arbitration cycle after each tail; grant ignores buffer_req while locked.
module out_port_rr_arbiter #(
  parameter int NUM_PORTS    = 5,
  parameter int PORT_ADDRESS = 0,
  parameter int DPORT_W      = 3,
  parameter int RR_MODE      = 1,
  parameter int OWN_W        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PORTS-1:0]         buffer_req,
  input  logic [NUM_PORTS*DPORT_W-1:0] buffer_dport,
  input  logic                         flit_xfer,
  input  logic                         flit_tail,
  output logic [NUM_PORTS-1:0]         buffer_grant,
  output logic                         busy,
  output logic [OWN_W-1:0]             owner
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t                 state;
  logic [OWN_W-1:0]       rr_ptr;
  logic [NUM_PORTS-1:0]   cand;
  logic [OWN_W-1:0]       search_start;
  logic [OWN_W-1:0]       win;
  logic [OWN_W-1:0]       win_next;
  logic [NUM_PORTS-1:0]   win_oh;

  // First set bit of c scanning upward from start, wrapping at NUM_PORTS.
  function automatic logic [OWN_W-1:0] pick_winner(input logic [NUM_PORTS-1:0] c,
                                                   input logic [OWN_W-1:0]     start);
    int   idx;
    logic found;
    pick_winner = '0;
    found       = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && c[idx]) begin
        pick_winner = OWN_W'(idx);
        found       = 1'b1;
      end
    end
  endfunction

  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand[i] = buffer_req[i] &&
                (buffer_dport[i*DPORT_W +: DPORT_W] == DPORT_W'(PORT_ADDRESS));
    end
  end

  // Fixed priority is round-robin with the search pinned at index 0.
  assign search_start = (RR_MODE != 0) ? rr_ptr : '0;
  assign win          = pick_winner(cand, search_start);
  assign win_next     = (win == OWN_W'(NUM_PORTS - 1)) ? '0 : win + OWN_W'(1);

  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      buffer_grant <= '0;
      busy         <= 1'b0;
      owner        <= '0;
      rr_ptr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|cand) begin
            state        <= LOCKED;
            buffer_grant <= win_oh;
            busy         <= 1'b1;
            owner        <= win;
            if (RR_MODE != 0) rr_ptr <= win_next;
          end
        end
        LOCKED: begin
          // Only the tail crossing the switch ends the packet; request drops are ignored.
          if (flit_xfer && flit_tail) begin
            state        <= IDLE;
            buffer_grant <= '0;
            busy         <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          buffer_grant <= '0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_port_rr_arbiter.sv
// Bench for out_port_rr_arbiter: a fixed-priority instance serving port 2 and a round-robin instance serving port 0 share one input stream.
module tb_out_port_rr_arbiter;
  localparam int N  = 5;
  localparam int DW = 3;
  localparam logic [14:0] DP_A = {3'd2, 3'd1, 3'd2, 3'd2, 3'd0};
  localparam logic [14:0] DP_3 = {3'd3, 3'd3, 3'd3, 3'd3, 3'd3};
  localparam logic [14:0] DP_2 = {3'd2, 3'd2, 3'd2, 3'd2, 3'd2};

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic [N-1:0]  req  = '0;
  logic [14:0]   dp   = '0;
  logic          xfer = 1'b0;
  logic          tail = 1'b0;
  logic [N-1:0]  g_fx, g_rr;
  logic          b_fx, b_rr;
  logic [2:0]    o_fx, o_rr;

  int n_cmp  = 0;
  int n_fail = 0;

  out_port_rr_arbiter #(.NUM_PORTS(N), .PORT_ADDRESS(2), .DPORT_W(DW), .RR_MODE(0)) dut_fx (
    .clk(clk), .rst(rst), .buffer_req(req), .buffer_dport(dp),
    .flit_xfer(xfer), .flit_tail(tail),
    .buffer_grant(g_fx), .busy(b_fx), .owner(o_fx));

  out_port_rr_arbiter #(.NUM_PORTS(N), .PORT_ADDRESS(0), .DPORT_W(DW), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .buffer_req(req), .buffer_dport(dp),
    .flit_xfer(xfer), .flit_tail(tail),
    .buffer_grant(g_rr), .busy(b_rr), .owner(o_rr));

  always #5 clk = ~clk;

  // Reference: an output is either free or held by one input; a free output
  // takes the first matching requester in search order (from 0, or from the
  // slot after the last winner in round-robin) and frees on a tail transfer.
  typedef struct {
    bit locked;
    int own;
    int ptr;
  } mdl_t;

  mdl_t m_fx, m_rr;

  function automatic mdl_t mstep(input mdl_t s, input bit rr, input int addr);
    int i;
    if (s.locked) begin
      if (xfer && tail) s.locked = 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        i = rr ? (s.ptr + k) % N : k;
        if (req[i] && int'(dp[i*DW +: DW]) == addr) begin
          s.locked = 1'b1;
          s.own    = i;
          if (rr) s.ptr = (i + 1) % N;
          break;
        end
      end
    end
    return s;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_models();
    chk("model fx grant", int'(g_fx), m_fx.locked ? (1 << m_fx.own) : 0);
    chk("model fx busy",  int'(b_fx), int'(m_fx.locked));
    if (m_fx.locked) chk("model fx owner", int'(o_fx), m_fx.own);
    chk("model rr grant", int'(g_rr), m_rr.locked ? (1 << m_rr.own) : 0);
    chk("model rr busy",  int'(b_rr), int'(m_rr.locked));
    if (m_rr.locked) chk("model rr owner", int'(o_rr), m_rr.own);
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [14:0] d, input bit x, input bit t);
    @(negedge clk);
    req  = r;
    dp   = d;
    xfer = x;
    tail = t;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      m_fx = mstep(m_fx, 1'b0, 2);
      m_rr = mstep(m_rr, 1'b1, 0);
    end
    #1;
    check_models();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    req  = '0;
    dp   = '0;
    xfer = 1'b0;
    tail = 1'b0;
    m_fx = '{0, 0, 0};
    m_rr = '{0, 0, 0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] r;
    logic [14:0]  d;
    bit           x;
    bit           t;
    logic [N-1:0] eg;
    bit           eb;
    int           eo;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // Fixed-priority instance, serving port 2; expectations are after the edge ending each row.
    tbl[0]  = '{5'b10110, DP_A, 1'b0, 1'b0, 5'b00010, 1'b1, 1};
    tbl[1]  = '{5'b10110, DP_A, 1'b1, 1'b0, 5'b00010, 1'b1, 1};
    tbl[2]  = '{5'b10110, DP_A, 1'b1, 1'b0, 5'b00010, 1'b1, 1};
    tbl[3]  = '{5'b10110, DP_A, 1'b1, 1'b0, 5'b00010, 1'b1, 1};
    tbl[4]  = '{5'b10110, DP_A, 1'b1, 1'b1, 5'b00000, 1'b0, 0};
    tbl[5]  = '{5'b10100, DP_A, 1'b0, 1'b0, 5'b00100, 1'b1, 2};
    tbl[6]  = '{5'b10100, DP_A, 1'b1, 1'b1, 5'b00000, 1'b0, 0};
    tbl[7]  = '{5'b11111, DP_3, 1'b0, 1'b0, 5'b00000, 1'b0, 0};
    tbl[8]  = '{5'b11111, DP_3, 1'b1, 1'b1, 5'b00000, 1'b0, 0};
    tbl[9]  = '{5'b11000, DP_2, 1'b0, 1'b0, 5'b01000, 1'b1, 3};
    tbl[10] = '{5'b11000, DP_2, 1'b1, 1'b1, 5'b00000, 1'b0, 0};
    tbl[11] = '{5'b10100, DP_2, 1'b0, 1'b0, 5'b00100, 1'b1, 2};
    tbl[12] = '{5'b10100, DP_2, 1'b1, 1'b1, 5'b00000, 1'b0, 0};

    m_fx = '{0, 0, 0};
    m_rr = '{0, 0, 0};
    #1;
    chk("reset async grant", int'(g_fx | g_rr), 0);
    do_reset();

    // Idle after reset
    for (int c = 0; c < 10; c++) begin
      drive('0, '0, 1'b0, 1'b0);
      tick();
      chk("idle fx grant", int'(g_fx), 0);
      chk("idle fx busy",  int'(b_fx), 0);
      chk("idle fx owner", int'(o_fx), 0);
      chk("idle rr grant", int'(g_rr), 0);
      chk("idle rr busy",  int'(b_rr), 0);
      chk("idle rr owner", int'(o_rr), 0);
    end

    foreach (tbl[v]) begin
      drive(tbl[v].r, tbl[v].d, tbl[v].x, tbl[v].t);
      tick();
      chk($sformatf("vec%0d grant", v), int'(g_fx), int'(tbl[v].eg));
      chk($sformatf("vec%0d busy", v),  int'(b_fx), int'(tbl[v].eb));
      if (tbl[v].eb) chk($sformatf("vec%0d owner", v), int'(o_fx), tbl[v].eo);
    end

    // Round-robin single-flit stream: a grant every second cycle, owners 0..4 then 0
    do_reset();
    for (int c = 0; c < 12; c++) begin
      drive(5'b11111, '0, 1'b1, 1'b1);
      tick();
      chk("rr stream busy", int'(b_rr), (c % 2 == 0) ? 1 : 0);
      chk("rr stream grant", int'(g_rr), (c % 2 == 0) ? (1 << ((c / 2) % N)) : 0);
      if (c % 2 == 0) chk("rr stream owner", int'(o_rr), (c / 2) % N);
    end

    // Lock is held through a dropped request and a competing requester
    do_reset();
    drive(5'b01000, '0, 1'b0, 1'b0);
    tick();
    chk("hold initial grant", int'(g_rr), 5'b01000);
    for (int c = 0; c < 4; c++) begin
      drive(5'b00001, '0, 1'b0, 1'b0);
      tick();
      chk("hold grant", int'(g_rr), 5'b01000);
    end
    drive(5'b00001, '0, 1'b1, 1'b1);
    tick();
    chk("hold release", int'(g_rr), 0);
    drive(5'b00001, '0, 1'b0, 1'b0);
    tick();
    chk("hold next owner", int'(g_rr), 5'b00001);

    // Asynchronous reset mid-packet with the pointer at 3
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(5'b00111, '0, 1'b1, 1'b1);
      tick();
    end
    drive(5'b00111, '0, 1'b0, 1'b0);
    tick();
    chk("areset pre grant", int'(g_rr), 5'b00100);
    drive(5'b00111, '0, 1'b1, 1'b0);
    tick();
    chk("areset body grant", int'(g_rr), 5'b00100);
    @(negedge clk);
    #2;
    rst  = 1'b1;
    m_fx = '{0, 0, 0};
    m_rr = '{0, 0, 0};
    #1;
    chk("areset grant drop", int'(g_rr), 0);
    chk("areset busy drop",  int'(b_rr), 0);
    @(negedge clk);
    rst  = 1'b0;
    req  = 5'b10010;
    dp   = '0;
    xfer = 1'b0;
    tail = 1'b0;
    tick();
    chk("areset pointer", int'(g_rr), 5'b00010);

    // Random traffic against the reference model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      logic [14:0] d;
      for (int i = 0; i < N; i++) d[i*DW +: DW] = 3'($urandom_range(0, 3));
      drive(5'($urandom), d, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
